// File: rtl/decodez.sv
// decodez: single-lane TMDS/HDMI symbol decoder.
//
// Classifies each word-aligned 10-bit TMDS symbol (control, TERC4, video and
// data-island guard bands), tracks the lane through its control, preamble,
// video, data-island and trailing-guard phases, and produces decoded video
// bytes, control bits and TERC4 nibbles. Every output is registered with a
// fixed two-clock latency from din.
//
// Parameters:
//   CHANNEL     "BLUE", "GREEN" or "RED": selects the lane's guard-band codes
//   ISLAND_LEN  packet symbols carried between the island guard bands
//
// Ports:
//   clkin        pixel clock, rising edge
//   rstin        asynchronous reset, active high
//   din          aligned TMDS symbol, one per clock
//   iPreVideo    video preamble indication, aligned with din
//   iPreIsland   data-island preamble indication, aligned with din
//   oData        decoded video byte, held while oDE is low
//   oDE          video data period
//   oC0, oC1     last decoded control bits
//   oTerc4       decoded island nibble, qualified by oTerc4Valid
//   oGuard       a guard-band symbol is being accepted
//   oErr         one-cycle pulse on an illegal symbol
//   oErrCount    saturating count of oErr pulses
module decodez #(
    parameter string       CHANNEL    = "BLUE",
    parameter int unsigned ISLAND_LEN = 64
) (
    input  logic        clkin,
    input  logic        rstin,
    input  logic [9:0]  din,
    input  logic        iPreVideo,
    input  logic        iPreIsland,
    output logic [7:0]  oData,
    output logic        oDE,
    output logic        oC0,
    output logic        oC1,
    output logic [3:0]  oTerc4,
    output logic        oTerc4Valid,
    output logic        oGuard,
    output logic        oErr,
    output logic [15:0] oErrCount
);

    localparam bit IsBlue  = (CHANNEL == "BLUE");
    localparam bit IsGreen = (CHANNEL == "GREEN");

    localparam int unsigned IcntW = $clog2(ISLAND_LEN + 1);
    localparam logic [IcntW-1:0] LastIdx = IcntW'(ISLAND_LEN - 1);

    localparam logic [9:0] GuardA = 10'b1011001100;
    localparam logic [9:0] GuardB = 10'b0100110011;

    typedef enum logic [2:0] {
        StCtl,
        StVarm,
        StVideo,
        StDarm,
        StData,
        StTrail
    } state_e;

    // ------------------------------------------------------------------
    // Stage 1: symbol classification
    // ------------------------------------------------------------------
    logic       ctl_hit;
    logic [1:0] ctl_code;
    logic       terc_hit;
    logic [3:0] terc_nib;
    logic       vgb_hit;
    logic       dgb_hit;

    always_comb begin
        ctl_hit  = 1'b1;
        ctl_code = 2'b00;
        case (din)
            10'b1101010100: ctl_code = 2'b00;
            10'b0010101011: ctl_code = 2'b01;
            10'b0101010100: ctl_code = 2'b10;
            10'b1010101011: ctl_code = 2'b11;
            default:        ctl_hit  = 1'b0;
        endcase
    end

    always_comb begin
        terc_hit = 1'b1;
        terc_nib = 4'h0;
        case (din)
            10'b1010011100: terc_nib = 4'h0;
            10'b1001100011: terc_nib = 4'h1;
            10'b1011100100: terc_nib = 4'h2;
            10'b1011100010: terc_nib = 4'h3;
            10'b0101110001: terc_nib = 4'h4;
            10'b0100011110: terc_nib = 4'h5;
            10'b0110001110: terc_nib = 4'h6;
            10'b0100111100: terc_nib = 4'h7;
            10'b1011001100: terc_nib = 4'h8;
            10'b0100111001: terc_nib = 4'h9;
            10'b0110011100: terc_nib = 4'hA;
            10'b1011000110: terc_nib = 4'hB;
            10'b1010001110: terc_nib = 4'hC;
            10'b1001110001: terc_nib = 4'hD;
            10'b0101100011: terc_nib = 4'hE;
            10'b1011000011: terc_nib = 4'hF;
            default:        terc_hit = 1'b0;
        endcase
    end

    // The blue lane carries HSYNC/VSYNC as TERC4 during island guard bands,
    // so its guard band is any TERC4 code whose upper two bits are set.
    always_comb begin
        vgb_hit = IsGreen ? (din == GuardB) : (din == GuardA);
        dgb_hit = IsBlue ? (terc_hit && (terc_nib[3:2] == 2'b11)) : (din == GuardB);
    end

    logic [9:0] s1_din_q;
    logic       s1_ctl_q;
    logic [1:0] s1_code_q;
    logic       s1_terc_q;
    logic [3:0] s1_nib_q;
    logic       s1_vgb_q;
    logic       s1_dgb_q;
    logic       s1_pre_v_q;
    logic       s1_pre_i_q;

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            s1_din_q   <= '0;
            s1_ctl_q   <= 1'b0;
            s1_code_q  <= '0;
            s1_terc_q  <= 1'b0;
            s1_nib_q   <= '0;
            s1_vgb_q   <= 1'b0;
            s1_dgb_q   <= 1'b0;
            s1_pre_v_q <= 1'b0;
            s1_pre_i_q <= 1'b0;
        end else begin
            s1_din_q   <= din;
            s1_ctl_q   <= ctl_hit;
            s1_code_q  <= ctl_code;
            s1_terc_q  <= terc_hit;
            s1_nib_q   <= terc_nib;
            s1_vgb_q   <= vgb_hit;
            s1_dgb_q   <= dgb_hit;
            s1_pre_v_q <= iPreVideo;
            s1_pre_i_q <= iPreIsland;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: video decode, FSM and registered outputs
    // ------------------------------------------------------------------
    logic [7:0] vid_q;
    logic [7:0] vid_byte;

    always_comb begin
        vid_q       = s1_din_q[9] ? ~s1_din_q[7:0] : s1_din_q[7:0];
        vid_byte    = '0;
        vid_byte[0] = vid_q[0];
        for (int i = 1; i < 8; i++) begin
            vid_byte[i] = s1_din_q[8] ? (vid_q[i] ^ vid_q[i-1]) : ~(vid_q[i] ^ vid_q[i-1]);
        end
    end

    state_e           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic             grd_q, grd_d;     // first of the two guard symbols seen
    logic [IcntW-1:0] icnt_q, icnt_d;

    logic pre_any;
    logic arm_guard;

    always_comb begin
        pre_any   = s1_pre_v_q | s1_pre_i_q;
        arm_guard = (state_q == StVarm) ? s1_vgb_q : s1_dgb_q;
    end

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            state_q <= StCtl;
            run_q   <= '0;
            grd_q   <= 1'b0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            grd_q   <= grd_d;
            icnt_q  <= icnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        grd_d   = grd_q;
        icnt_d  = icnt_q;
        case (state_q)
            StCtl: begin
                if (s1_ctl_q && pre_any) begin
                    if (run_q == 4'd7) begin
                        run_d   = '0;
                        grd_d   = 1'b0;
                        // Video preamble takes priority if both are flagged.
                        state_d = s1_pre_v_q ? StVarm : StDarm;
                    end else begin
                        run_d = run_q + 4'd1;
                    end
                end else begin
                    run_d = '0;
                end
            end
            StVarm, StDarm: begin
                if (arm_guard) begin
                    if (grd_q) begin
                        state_d = (state_q == StVarm) ? StVideo : StData;
                        grd_d   = 1'b0;
                        icnt_d  = '0;
                    end else begin
                        grd_d = 1'b1;
                    end
                end else if (s1_ctl_q && pre_any) begin
                    grd_d = 1'b0;
                end else begin
                    state_d = StCtl;
                end
            end
            StVideo: begin
                if (s1_ctl_q) begin
                    state_d = StCtl;
                end
            end
            StData: begin
                if (s1_terc_q) begin
                    icnt_d = icnt_q + IcntW'(1);
                    if (icnt_q == LastIdx) begin
                        state_d = StTrail;
                        grd_d   = 1'b0;
                    end
                end else begin
                    state_d = StCtl;
                end
            end
            StTrail: begin
                if (s1_dgb_q) begin
                    if (grd_q) begin
                        state_d = StCtl;
                    end else begin
                        grd_d = 1'b1;
                    end
                end else begin
                    state_d = StCtl;
                end
            end
            default: state_d = StCtl;
        endcase
    end

    logic [7:0]  data_q, data_d;
    logic        de_q, de_d;
    logic [1:0]  c_q, c_d;
    logic [3:0]  terc_q, terc_d;
    logic        tv_q, tv_d;
    logic        guard_q, guard_d;
    logic        err_q, err_d;
    logic [15:0] err_cnt_q;

    always_comb begin
        data_d  = data_q;
        c_d     = c_q;
        terc_d  = terc_q;
        de_d    = 1'b0;
        tv_d    = 1'b0;
        guard_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StCtl: begin
                if (s1_ctl_q) begin
                    c_d = s1_code_q;
                end
            end
            StVarm, StDarm: begin
                if (arm_guard) begin
                    guard_d = 1'b1;
                end else if (s1_ctl_q && pre_any) begin
                    c_d = s1_code_q;
                end else begin
                    err_d = 1'b1;
                end
            end
            StVideo: begin
                // The closing control symbol is decoded as control, not video.
                if (s1_ctl_q) begin
                    c_d = s1_code_q;
                end else begin
                    de_d   = 1'b1;
                    data_d = vid_byte;
                end
            end
            StData: begin
                if (s1_terc_q) begin
                    tv_d   = 1'b1;
                    terc_d = s1_nib_q;
                end else begin
                    err_d = 1'b1;
                end
            end
            StTrail: begin
                if (s1_dgb_q) begin
                    guard_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            data_q    <= '0;
            de_q      <= 1'b0;
            c_q       <= '0;
            terc_q    <= '0;
            tv_q      <= 1'b0;
            guard_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            data_q  <= data_d;
            de_q    <= de_d;
            c_q     <= c_d;
            terc_q  <= terc_d;
            tv_q    <= tv_d;
            guard_q <= guard_d;
            err_q   <= err_d;
            if (err_d && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign oData       = data_q;
    assign oDE         = de_q;
    assign oC0         = c_q[0];
    assign oC1         = c_q[1];
    assign oTerc4      = terc_q;
    assign oTerc4Valid = tv_q;
    assign oGuard      = guard_q;
    assign oErr        = err_q;
    assign oErrCount   = err_cnt_q;

endmodule

// File: doc/decodez.md
DECODEZ -- requirements
Module: decodez

Interface
REQ-001 SHALL have parameter CHANNEL, default "BLUE", which selects the TMDS lane decoded ("BLUE", "GREEN" or "RED").
REQ-002 SHALL have parameter ISLAND_LEN, default 64, giving the number of data-island packet symbols between the guard bands.
REQ-003 SHALL have port clkin, input, 1 bit: pixel clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rstin, input, 1 bit: asynchronous reset, active-high.
REQ-005 SHALL have port din, input, 10 bits: word-aligned TMDS symbol, one per clock.
REQ-006 SHALL have ports iPreVideo and iPreIsland, input, 1 bit each: lane-group preamble indications, aligned with din.
REQ-007 SHALL have port oData, output, 8 bits: decoded video byte.
REQ-008 SHALL have port oDE, output, 1 bit: video data period.
REQ-009 SHALL have ports oC0 and oC1, output, 1 bit each: last decoded control bits.
REQ-010 SHALL have port oTerc4, output, 4 bits: decoded island nibble; oTerc4Valid, output, 1 bit, marks it valid.
REQ-011 SHALL have port oGuard, output, 1 bit: a guard-band symbol is being accepted.
REQ-012 SHALL have port oErr, output, 1 bit: one-cycle pulse on an illegal symbol.
REQ-013 SHALL have port oErrCount, output, 16 bits: saturating error count.

Function
REQ-014 SHALL register all outputs with a fixed latency of 2 clocks: stage 1 registers din plus classification flags (isCTL, isTERC4, isVGB, isDGB); stage 2 registers the decoded outputs.
REQ-015 SHALL match CTL codes exactly: 1101010100 -> {c1,c0}=00, 0010101011 -> 01, 0101010100 -> 10, 1010101011 -> 11.
REQ-016 SHALL decode TERC4 through the inverse of the 16-entry HDMI TERC4 table; any other symbol SHALL be non-TERC4.
REQ-017 SHALL use video guard band 1011001100 for BLUE and RED and 0100110011 for GREEN; data-island guard band 0100110011 for GREEN/RED; for BLUE, the island guard band is any TERC4 symbol with nibble[3:2]=11.
REQ-018 SHALL decode video as follows: q=din[9]?~din[7:0]:din[7:0]; d0=q0; di=din[8]?(qi^qi-1):~(qi^qi-1).
REQ-019 SHALL implement FSM states CTL, VARM, VIDEO, DARM, DATA and TRAIL; the reset state SHALL be CTL.
REQ-020 In CTL, SHALL update oC0/oC1 on each CTL symbol; a 4-bit run counter increments while isCTL and (iPreVideo or iPreIsland), and otherwise clears.
REQ-021 When run reaches 8, SHALL go to VARM if iPreVideo, else DARM; if both are asserted, iPreVideo SHALL win.
REQ-022 In VARM, further preamble CTL symbols SHALL hold the state; 2 consecutive VGB symbols (oGuard=1) SHALL go to VIDEO; any other symbol SHALL pulse oErr and go to CTL.
REQ-023 In VIDEO, oDE SHALL be 1 with oData per REQ-018; a CTL symbol SHALL go to CTL with oDE=0 in that same output cycle, and that symbol SHALL be decoded as control.
REQ-024 In DARM, 2 consecutive DGB symbols SHALL go to DATA; otherwise DARM SHALL behave as VARM.
REQ-025 In DATA, oTerc4Valid SHALL be 1 for exactly ISLAND_LEN symbols; a non-TERC4 symbol SHALL pulse oErr, drop oTerc4Valid and go to CTL.
REQ-026 In TRAIL, 2 DGB symbols SHALL be accepted (oGuard=1), followed by CTL; a wrong symbol SHALL pulse oErr and go to CTL.
REQ-027 oC0/oC1 SHALL hold their value outside CTL symbols; oData SHALL hold while oDE=0.
REQ-028 oErrCount SHALL increment on each oErr and saturate at 0xFFFF.
REQ-029 A symbol that is not CTL while in the CTL state SHALL clear run and SHALL NOT signal oErr.

Reset
REQ-030 Asserting rstin SHALL immediately clear all outputs, both pipeline stages, run, the island counter and oErrCount, and SHALL force state CTL, including mid-VIDEO or mid-DATA.
REQ-031 After rstin deasserts, the first valid output SHALL appear 2 clocks after the first symbol.

Verification
REQ-032 Scenario 1: 8x 0010101011 with iPreVideo=1, then 2x 1011001100, then 0x100 and 0x200 (BLUE) -> oGuard high 2 cycles, then oDE=1 with oData=00 then FF.
REQ-033 Scenario 2: VIDEO followed by 1101010100 -> oDE falls on that symbol's output cycle and {oC1,oC0}=00.
REQ-034 Scenario 3: GREEN with 8 preamble symbols and iPreIsland, 2x 0100110011, 64x 1010011100, 2x 0100110011 -> oTerc4Valid high 64 cycles with oTerc4=0000, oGuard high 2+2 cycles, oErr never set.
REQ-035 Scenario 4: a 0x3FF symbol in DATA -> oErr pulses 1 cycle, oErrCount goes 0->1, state returns to CTL.
REQ-036 Scenario 5: preamble broken after 7 symbols -> state stays CTL and a following VGB is not flagged as oGuard.
REQ-037 Scenario 6: rstin pulse mid-VIDEO -> oDE=0, oData=00 and oErrCount=0 immediately; a full 8-symbol preamble is then needed before video is accepted again.
